core_wb_unit: RTL and testbench

//  Parametrised writeback stage for the pipeline, sitting after execute.
//  - Retires one instruction at a time: GPR writeback, single-shot CSR access, load data alignment.
//  - Waits for data memory responses with a timeout.
//  - Arbitrates synchronous traps against interrupts and drives the control-flow redirect handshake.
//

---
 rtl/core_wb_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 tb/tb_core_wb_unit.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_unit.sv
// -----------------------------------------------------------------------------
// core_wb_unit
//
// Writeback stage that sits after execute. It retires one instruction at a
// time:
//   - GPR writeback of ALU, CSR or load results
//   - single-shot CSR access
//   - load data alignment and sign extension
//   - waiting for a data memory response, with a timeout
//   - arbitration of synchronous traps against interrupts, and the
//     control-flow redirect handshake (cf_valid / cf_ack)
//
// Parameters
//   XLEN         datapath width, 32 or 64
//   RSP_TIMEOUT  maximum MEMW cycles without a response before an
//                access-fault trap (>= 1)
//
// Optional feature macro
//   WB_MISALIGN_TRAP_EN
//     Defined: an LSU address not aligned to its access size traps in ACT
//     (cause 4 load / 6 store, mtval = address) without touching memory.
//     Undefined: no alignment check; shifted load data is zero-filled above
//     the fetched bytes.
//
// Ports
//   g_clk, g_resetn            clock, async active-low reset
//   s3_*                       instruction from execute (valid/ready)
//   dmem_rsp_*, dmem_rdata     data memory response
//   csr_*                      single-cycle CSR access port
//   rd_*                       GPR write port
//   int_*                      interrupt request / acknowledge
//   mtvec_base                 synchronous exception vector
//   cf_valid/cf_ack/cf_target  redirect handshake
//   trap_*                     committed trap report
//   instr_ret                  instruction retired strobe
//
// FSM states
//   state  | meaning
//   IDLE   | no instruction held, ready for a new one
//   ACT    | instruction registered; priority evaluation and retire/CSR
//   MEMW   | load/store waiting for dmem response, timeout counter running
//   TRAP   | redirect requested, waiting for cf_ack to commit the trap
// -----------------------------------------------------------------------------
module core_wb_unit #(
    parameter int XLEN        = 64,
    parameter int RSP_TIMEOUT = 16
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            s3_valid,
    output logic            s3_ready,
    input  logic [XLEN-1:0] s3_pc,
    input  logic [31:0]     s3_instr,
    input  logic [XLEN-1:0] s3_wdata,
    input  logic [4:0]      s3_rd,
    input  logic [1:0]      s3_wb_sel,
    input  logic [6:0]      s3_lsu_op,
    input  logic [2:0]      s3_csr_op,
    input  logic [11:0]     s3_csr_addr,
    input  logic            s3_trap,
    input  logic [5:0]      s3_cause,
    input  logic            dmem_rsp_valid,
    input  logic            dmem_rsp_err,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            csr_en,
    output logic [2:0]      csr_op,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_error,
    output logic            rd_wen,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    input  logic            int_pending,
    input  logic [5:0]      int_cause,
    input  logic [XLEN-1:0] int_tvec,
    output logic            int_ack,
    input  logic [XLEN-1:0] mtvec_base,
    output logic            cf_valid,
    input  logic            cf_ack,
    output logic [XLEN-1:0] cf_target,
    output logic            trap_valid,
    output logic            trap_int,
    output logic [5:0]      trap_cause,
    output logic [XLEN-1:0] trap_mtval,
    output logic [XLEN-1:0] trap_pc,
    output logic            instr_ret
);

    localparam int OW = $clog2(XLEN / 8);
    localparam int CW = $clog2(RSP_TIMEOUT + 1);

    localparam logic [XLEN-1:0] M8  = XLEN'(8'hFF);
    localparam logic [XLEN-1:0] M16 = XLEN'(16'hFFFF);
    localparam logic [XLEN-1:0] M32 = XLEN'(32'hFFFF_FFFF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACT  = 2'd1,
        S_MEMW = 2'd2,
        S_TRAP = 2'd3
    } state_t;

    state_t state, state_nx;

    // Registered instruction fields
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic [1:0]      r_wb_sel;
    logic [6:0]      r_lsu_op;
    logic [2:0]      r_csr_op;
    logic [11:0]     r_csr_addr;
    logic            r_trap;
    logic [5:0]      r_cause;

    // Trap information latched when the FSM decides to enter TRAP
    logic            t_int;
    logic [5:0]      t_cause;
    logic [XLEN-1:0] t_mtval;
    logic [XLEN-1:0] t_tvec;

    logic [CW-1:0]   cnt;

    // Decision signals from the next-state logic
    logic            retire;
    logic            go_trap;
    logic            nx_int;
    logic [5:0]      nx_cause;
    logic [XLEN-1:0] nx_mtval;
    logic            csr_fire;
    logic            wb_from_csr;
    logic            wb_from_mem;
    logic            enter_memw;

    logic            is_load;
    logic            is_store;
    logic            is_lsu;
    logic            csr_acc;
    logic            accept;
    logic            in_trap;

    logic [XLEN-1:0] ld_sh;
    logic [XLEN-1:0] ld_data;

    assign is_load  = r_lsu_op[0];
    assign is_store = r_lsu_op[1];
    assign is_lsu   = is_load | is_store;
    assign csr_acc  = |r_csr_op;
    assign accept   = s3_valid & s3_ready;
    assign in_trap  = (state == S_TRAP);

`ifdef WB_MISALIGN_TRAP_EN
    logic [2:0] addr_lo;
    logic       misalign;

    assign addr_lo = r_wdata[2:0];

    // Double accesses fall back to word alignment on a 32-bit datapath.
    always_comb begin
        misalign = 1'b0;
        if (r_lsu_op[2]) begin
            misalign = 1'b0;
        end else if (r_lsu_op[3]) begin
            misalign = addr_lo[0];
        end else if (r_lsu_op[4] || (XLEN == 32 && r_lsu_op[5])) begin
            misalign = |addr_lo[1:0];
        end else if (r_lsu_op[5]) begin
            misalign = |addr_lo[2:0];
        end
    end
`endif

    // Load alignment: shift the addressed byte down to bit 0, then trim to
    // the access size. The shift zero-fills, so a misaligned access that
    // runs off the top of the bus word returns zeros for the missing bytes.
    always_comb begin
        ld_sh   = dmem_rdata >> {r_wdata[OW-1:0], 3'b000};
        ld_data = ld_sh;
        if (r_lsu_op[2]) begin
            ld_data = ld_sh & M8;
            if (r_lsu_op[6] && ld_sh[7]) ld_data = ld_data | ~M8;
        end else if (r_lsu_op[3]) begin
            ld_data = ld_sh & M16;
            if (r_lsu_op[6] && ld_sh[15]) ld_data = ld_data | ~M16;
        end else if (r_lsu_op[4] || (XLEN == 32 && r_lsu_op[5])) begin
            ld_data = ld_sh & M32;
            if (r_lsu_op[6] && ld_sh[31]) ld_data = ld_data | ~M32;
        end
    end

    // State register and datapath registers
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_pc       <= '0;
            r_instr    <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_wb_sel   <= '0;
            r_lsu_op   <= '0;
            r_csr_op   <= '0;
            r_csr_addr <= '0;
            r_trap     <= 1'b0;
            r_cause    <= '0;
            t_int      <= 1'b0;
            t_cause    <= '0;
            t_mtval    <= '0;
            t_tvec     <= '0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                r_pc       <= s3_pc;
                r_instr    <= s3_instr;
                r_wdata    <= s3_wdata;
                r_rd       <= s3_rd;
                r_wb_sel   <= s3_wb_sel;
                r_lsu_op   <= s3_lsu_op;
                r_csr_op   <= s3_csr_op;
                r_csr_addr <= s3_csr_addr;
                r_trap     <= s3_trap;
                r_cause    <= s3_cause;
            end
            if (go_trap) begin
                t_int   <= nx_int;
                t_cause <= nx_cause;
                t_mtval <= nx_mtval;
                // The vector is captured here so a later drop of
                // int_pending cannot change the redirect target.
                if (nx_int) t_tvec <= int_tvec;
            end
            if (enter_memw) begin
                cnt <= '0;
            end else if (state == S_MEMW) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx    = state;
        retire      = 1'b0;
        go_trap     = 1'b0;
        nx_int      = 1'b0;
        nx_cause    = '0;
        nx_mtval    = '0;
        csr_fire    = 1'b0;
        wb_from_csr = 1'b0;
        wb_from_mem = 1'b0;
        enter_memw  = 1'b0;

        case (state)
            S_IDLE: begin
                if (s3_valid) state_nx = S_ACT;
            end
            S_ACT: begin
                // Interrupts are deferred on LSU instructions so a memory
                // access is never abandoned halfway.
                if (int_pending && !is_lsu) begin
                    go_trap  = 1'b1;
                    nx_int   = 1'b1;
                    nx_cause = int_cause;
                end else if (r_trap) begin
                    go_trap  = 1'b1;
                    nx_cause = r_cause;
`ifdef WB_MISALIGN_TRAP_EN
                end else if (is_lsu && misalign) begin
                    go_trap  = 1'b1;
                    nx_cause = is_load ? 6'd4 : 6'd6;
                    nx_mtval = r_wdata;
`endif
                end else if (csr_acc) begin
                    csr_fire = 1'b1;
                    if (csr_error) begin
                        go_trap  = 1'b1;
                        nx_cause = 6'd2;
                        nx_mtval = XLEN'(r_instr);
                    end else begin
                        retire      = 1'b1;
                        wb_from_csr = 1'b1;
                    end
                end else if (is_lsu) begin
                    state_nx   = S_MEMW;
                    enter_memw = 1'b1;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEMW: begin
                // A good response in the timeout cycle still wins.
                if (dmem_rsp_valid && !dmem_rsp_err) begin
                    retire      = 1'b1;
                    wb_from_mem = is_load;
                end else if (dmem_rsp_err || cnt == CW'(RSP_TIMEOUT - 1)) begin
                    go_trap  = 1'b1;
                    nx_cause = is_load ? 6'd5 : 6'd7;
                    nx_mtval = r_wdata;
                end
            end
            S_TRAP: begin
                if (cf_ack) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (go_trap) begin
            state_nx = S_TRAP;
        end else if (retire) begin
            state_nx = s3_valid ? S_ACT : S_IDLE;
        end
    end

    // Output logic
    always_comb begin
        s3_ready   = (state == S_IDLE) || retire;
        csr_en     = csr_fire;
        csr_op     = r_csr_op;
        csr_addr   = r_csr_addr;
        csr_wdata  = r_wdata;

        rd_wen     = retire && (r_wb_sel != 2'b00) && (r_rd != 5'd0) && !is_store;
        rd_addr    = r_rd;
        rd_wdata   = r_wdata;
        if (wb_from_csr) begin
            rd_wdata = csr_rdata;
        end else if (wb_from_mem) begin
            rd_wdata = ld_data;
        end

        cf_valid   = in_trap;
        cf_target  = '0;
        trap_cause = '0;
        trap_mtval = '0;
        trap_pc    = '0;
        if (in_trap) begin
            cf_target  = t_int ? t_tvec : mtvec_base;
            trap_cause = t_cause;
            trap_mtval = t_mtval;
            trap_pc    = r_pc;
        end

        trap_valid = in_trap && cf_ack;
        trap_int   = trap_valid && t_int;
        int_ack    = trap_valid && t_int;
        instr_ret  = retire || (trap_valid && !t_int);
    end

endmodule

// File: tb/tb_core_wb_unit.sv
module tb_core_wb_unit;

    localparam int XLEN = 64;
    localparam int RT   = 4;
`ifdef WB_MISALIGN_TRAP_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic            g_clk, g_resetn;
    logic            s3_valid, s3_ready;
    logic [63:0]     s3_pc, s3_wdata;
    logic [31:0]     s3_instr;
    logic [4:0]      s3_rd;
    logic [1:0]      s3_wb_sel;
    logic [6:0]      s3_lsu_op;
    logic [2:0]      s3_csr_op;
    logic [11:0]     s3_csr_addr;
    logic            s3_trap;
    logic [5:0]      s3_cause;
    logic            dmem_rsp_valid, dmem_rsp_err;
    logic [63:0]     dmem_rdata;
    logic            csr_en;
    logic [2:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [63:0]     csr_wdata, csr_rdata;
    logic            csr_error;
    logic            rd_wen;
    logic [4:0]      rd_addr;
    logic [63:0]     rd_wdata;
    logic            int_pending;
    logic [5:0]      int_cause;
    logic [63:0]     int_tvec;
    logic            int_ack;
    logic [63:0]     mtvec_base;
    logic            cf_valid, cf_ack;
    logic [63:0]     cf_target;
    logic            trap_valid, trap_int;
    logic [5:0]      trap_cause;
    logic [63:0]     trap_mtval, trap_pc;
    logic            instr_ret;

    core_wb_unit #(.XLEN(XLEN), .RSP_TIMEOUT(RT)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .s3_valid(s3_valid), .s3_ready(s3_ready), .s3_pc(s3_pc), .s3_instr(s3_instr),
        .s3_wdata(s3_wdata), .s3_rd(s3_rd), .s3_wb_sel(s3_wb_sel), .s3_lsu_op(s3_lsu_op),
        .s3_csr_op(s3_csr_op), .s3_csr_addr(s3_csr_addr), .s3_trap(s3_trap), .s3_cause(s3_cause),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_err(dmem_rsp_err), .dmem_rdata(dmem_rdata),
        .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_error(csr_error),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .int_pending(int_pending), .int_cause(int_cause), .int_tvec(int_tvec), .int_ack(int_ack),
        .mtvec_base(mtvec_base), .cf_valid(cf_valid), .cf_ack(cf_ack), .cf_target(cf_target),
        .trap_valid(trap_valid), .trap_int(trap_int), .trap_cause(trap_cause),
        .trap_mtval(trap_mtval), .trap_pc(trap_pc), .instr_ret(instr_ret)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [6:0]  lsu;
        logic [2:0]  csr_op;
        logic [11:0] csr_addr;
        logic        trap;
        logic [5:0]  cause;
        logic        int_p;
        logic [5:0]  int_cause;
        logic [63:0] int_tvec;
        logic [63:0] mtvec;
        logic [63:0] csr_rdata;
        logic        csr_err;
        int          rsp_k;      // MEMW cycle of the response; >= RT means none
        logic        rsp_err;
        logic [63:0] rdata;
        int          ack_d;
    } stim_t;

    typedef struct {
        logic        trap;
        logic        intr;
        logic [5:0]  cause;
        logic [63:0] mtval;
        logic [63:0] pc;
        logic [63:0] target;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        int          lat;
        int          hold;
        int          csr_n;
        logic        memw;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ev_cnt   = 0;
    int   hold_cnt = 0;
    int   csr_cnt  = 0;
    int   ack_delay = 0;
    int   ack_cnt   = 0;

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    always @(posedge g_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: what one instruction does, given its environment.
    function automatic int size_bytes(input logic [6:0] lsu);
        if (lsu[2]) return 1;
        if (lsu[3]) return 2;
        if (lsu[4]) return 4;
        if (lsu[5]) return 8;
        return 0;
    endfunction

    function automatic logic [63:0] load_value(input stim_t s);
        logic [63:0] v;
        int n, off;
        n   = size_bytes(s.lsu);
        if (n == 0) n = 8;
        off = int'(s.wdata[2:0]);
        v   = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = s.rdata[8*(off+i) +: 8];
        if (s.lsu[6] && n < 8 && v[8*n-1])
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic ld, st;
        int   n;
        bit   retire;
        ld = s.lsu[0];
        st = s.lsu[1];
        n  = size_bytes(s.lsu);
        e  = '{default: 0};
        e.pc = s.pc;
        e.rd = s.rd;
        e.target = s.mtvec;
        retire = 0;
        if (s.int_p && !ld && !st) begin
            e.trap = 1; e.intr = 1; e.cause = s.int_cause; e.target = s.int_tvec;
            e.lat = 1 + s.ack_d;
        end else if (s.trap) begin
            e.trap = 1; e.cause = s.cause; e.lat = 1 + s.ack_d;
        end else if (MIS && (ld || st) && n > 1 && (s.wdata % n) != 0) begin
            e.trap = 1; e.cause = ld ? 6'd4 : 6'd6; e.mtval = s.wdata; e.lat = 1 + s.ack_d;
        end else if (s.csr_op != 3'b000) begin
            e.csr_n = 1;
            if (s.csr_err) begin
                e.trap = 1; e.cause = 6'd2; e.mtval = {32'b0, s.instr}; e.lat = 1 + s.ack_d;
            end else begin
                retire = 1; e.wdata = s.csr_rdata; e.lat = 0;
            end
        end else if (ld || st) begin
            e.memw = 1;
            if (s.rsp_k < RT && !s.rsp_err) begin
                retire = 1; e.wdata = load_value(s); e.lat = 1 + s.rsp_k;
            end else begin
                e.trap = 1; e.cause = ld ? 6'd5 : 6'd7; e.mtval = s.wdata;
                e.lat = (s.rsp_k < RT) ? 2 + s.rsp_k + s.ack_d : RT + 1 + s.ack_d;
            end
        end else begin
            retire = 1; e.wdata = s.wdata; e.lat = 0;
        end
        e.wen  = retire && s.wb_sel != 2'b00 && s.rd != 5'd0 && !st;
        e.hold = e.trap ? s.ack_d + 1 : 0;
        return e;
    endfunction

    // Redirect acceptor: acks cf_valid after ack_delay extra cycles.
    initial begin
        cf_ack = 1'b0;
        forever begin
            @(posedge g_clk);
            #1;
            if (cf_valid && g_resetn) begin
                if (ack_cnt == ack_delay) cf_ack = 1'b1;
                else begin cf_ack = 1'b0; ack_cnt++; end
            end else begin
                cf_ack  = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever an instruction completes.
    always @(negedge g_clk) begin
        if (!g_resetn) begin
            hold_cnt = 0;
            csr_cnt  = 0;
        end else begin
            if (cf_valid) hold_cnt++;
            if (csr_en)   csr_cnt++;
            if (instr_ret || trap_valid) begin
                exp_t e;
                ev_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", {62'b0, trap_valid, instr_ret}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("trap_valid", trap_valid, e.trap);
                    chk("trap_int", trap_int, e.intr);
                    chk("int_ack", int_ack, e.intr);
                    chk("instr_ret", instr_ret, !e.intr);
                    chk("rd_wen", rd_wen, e.wen);
                    chk("s3_ready_at_done", s3_ready, !e.trap);
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("csr_en_pulses", 64'(csr_cnt), 64'(e.csr_n));
                    if (e.wen) begin
                        chk("rd_addr", rd_addr, e.rd);
                        chk("rd_wdata", rd_wdata, e.wdata);
                    end
                    if (e.trap) begin
                        chk("trap_cause", trap_cause, e.cause);
                        chk("trap_mtval", trap_mtval, e.mtval);
                        chk("trap_pc", trap_pc, e.pc);
                        chk("cf_target", cf_target, e.target);
                        chk("cf_valid_cycles", 64'(hold_cnt), 64'(e.hold));
                    end
                end
                hold_cnt = 0;
                csr_cnt  = 0;
            end
        end
    end

    function automatic stim_t blank();
        stim_t s;
        s = '{default: 0};
        s.pc     = 64'h0000_0000_0000_1000;
        s.instr  = 32'h0000_0013;
        s.mtvec  = 64'h0000_0000_8000_0000;
        s.rsp_k  = 1;
        return s;
    endfunction

    task automatic set_env(input stim_t s);
        int_pending = s.int_p;
        int_cause   = s.int_cause;
        int_tvec    = s.int_tvec;
        mtvec_base  = s.mtvec;
        csr_rdata   = s.csr_rdata;
        csr_error   = s.csr_err;
        ack_delay   = s.ack_d;
    endtask

    task automatic drive_fields(input stim_t s);
        s3_valid    = 1'b1;
        s3_pc       = s.pc;
        s3_instr    = s.instr;
        s3_wdata    = s.wdata;
        s3_rd       = s.rd;
        s3_wb_sel   = s.wb_sel;
        s3_lsu_op   = s.lsu;
        s3_csr_op   = s.csr_op;
        s3_csr_addr = s.csr_addr;
        s3_trap     = s.trap;
        s3_cause    = s.cause;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge g_clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge g_clk);
        #1;
    endtask

    task automatic run_instr(input stim_t s);
        exp_t e;
        e = model(s);
        set_env(s);
        drive_fields(s);
        @(posedge g_clk);
        #1;
        s3_valid = 1'b0;
        e.acc = cyc;
        exp_q.push_back(e);
        if (e.memw && s.rsp_k < RT) begin
            repeat (1 + s.rsp_k) @(posedge g_clk);
            #1;
            dmem_rsp_valid = 1'b1;
            dmem_rsp_err   = s.rsp_err;
            dmem_rdata     = s.rdata;
            @(posedge g_clk);
            #1;
            dmem_rsp_valid = 1'b0;
            dmem_rsp_err   = 1'b0;
        end
        wait_drain();
    endtask

    task automatic burst3();
        stim_t s;
        exp_t  e;
        s = blank();
        set_env(s);
        for (int i = 0; i < 3; i++) begin
            s.rd     = 5'(i + 1);
            s.wb_sel = 2'b01;
            s.wdata  = {$urandom, $urandom};
            s.pc     = 64'h2000 + 64'(4 * i);
            e = model(s);
            drive_fields(s);
            @(posedge g_clk);
            #1;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        s3_valid = 1'b0;
        wait_drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s3_ready"}, s3_ready, 1'b1);
        chk({tag, "_strobes"}, {57'b0, cf_valid, trap_valid, trap_int, int_ack, instr_ret, rd_wen, csr_en}, 64'd0);
        chk({tag, "_data"}, rd_wdata | cf_target | trap_mtval | trap_pc | csr_wdata, 64'd0);
        chk({tag, "_ctl"}, {37'b0, rd_addr, csr_addr, csr_op, trap_cause}, 64'd0);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        logic [3:0] sz;
        int kind;
        s = blank();
        s.pc       = {$urandom, $urandom} & ~64'h3;
        s.instr    = $urandom;
        s.rd       = 5'($urandom_range(0, 31));
        s.wb_sel   = 2'($urandom_range(0, 3));
        s.wdata    = {$urandom, $urandom};
        s.csr_addr = 12'($urandom);
        kind       = $urandom_range(0, 5);
        sz         = 4'b0001 << $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 0) s.wdata[2:0] = 3'b000;
        case (kind)
            2: s.lsu = {1'($urandom_range(0, 1)), sz, 2'b01};
            3: s.lsu = {1'b0, sz, 2'b10};
            4: s.csr_op = 3'($urandom_range(1, 7));
            5: begin
                s.trap  = 1'b1;
                s.cause = 6'($urandom);
                if ($urandom_range(0, 1) == 1) s.lsu = {1'b0, sz, 2'b01};
            end
            default: ;
        endcase
        s.int_p     = ($urandom_range(0, 4) == 0);
        s.int_cause = 6'($urandom);
        s.int_tvec  = {$urandom, $urandom};
        s.mtvec     = {$urandom, $urandom};
        s.csr_rdata = {$urandom, $urandom};
        s.csr_err   = ($urandom_range(0, 3) == 0);
        s.rsp_k     = $urandom_range(0, RT + 1);
        s.rsp_err   = ($urandom_range(0, 5) == 0);
        s.rdata     = {$urandom, $urandom};
        s.ack_d     = $urandom_range(0, 3);
        return s;
    endfunction

    initial begin
        stim_t s;
        int    ev0;
        g_resetn = 1'b0;
        s3_valid = 1'b0; s3_pc = '0; s3_instr = '0; s3_wdata = '0; s3_rd = '0;
        s3_wb_sel = '0; s3_lsu_op = '0; s3_csr_op = '0; s3_csr_addr = '0;
        s3_trap = 1'b0; s3_cause = '0;
        dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0; dmem_rdata = '0;
        csr_rdata = '0; csr_error = 1'b0;
        int_pending = 1'b0; int_cause = '0; int_tvec = '0; mtvec_base = '0;
        repeat (2) @(posedge g_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        // LB sign-extended from byte 3
        s = blank();
        s.lsu = 7'b100_0101; s.wdata = 64'h0000_0000_0000_1003; s.rd = 5'd5; s.wb_sel = 2'b10;
        s.rdata = 64'h0000_0000_8000_0000; s.rsp_k = 1;
        run_instr(s);

        // CSRRW with CSR error
        s = blank();
        s.csr_op = 3'b001; s.csr_addr = 12'h340; s.instr = 32'h3402_9073;
        s.csr_err = 1'b1; s.rd = 5'd7; s.wb_sel = 2'b11; s.mtvec = 64'h0000_0000_8000_0000;
        run_instr(s);

        // Interrupt on an ADD with a delayed redirect ack
        s = blank();
        s.rd = 5'd3; s.wb_sel = 2'b01; s.wdata = 64'h1234;
        s.int_p = 1'b1; s.int_cause = 6'd7; s.int_tvec = 64'h0000_0000_8000_0100; s.ack_d = 3;
        run_instr(s);

        // LW with no response: timeout
        s = blank();
        s.lsu = 7'b001_0001; s.wdata = 64'h0000_0000_0000_2000; s.rd = 5'd9; s.wb_sel = 2'b10;
        s.rsp_k = 99;
        run_instr(s);

        // Response in the timeout cycle wins
        s = blank();
        s.lsu = 7'b001_0001; s.wdata = 64'h0000_0000_0000_2004; s.rd = 5'd9; s.wb_sel = 2'b10;
        s.rsp_k = RT - 1; s.rdata = 64'hCAFE_F00D_1122_3344;
        run_instr(s);

        // Back-to-back ALU instructions
        burst3();

        // Misaligned LW
        s = blank();
        s.lsu = 7'b001_0001; s.wdata = 64'h0000_0000_0000_1002; s.rd = 5'd4; s.wb_sel = 2'b10;
        s.rsp_k = 2; s.rdata = 64'h8899_AABB_CCDD_EEFF;
        run_instr(s);

        // Reset in the middle of MEMW, then an orphan response
        s = blank();
        s.lsu = 7'b001_0001; s.wdata = 64'h3000; s.rd = 5'd2; s.wb_sel = 2'b10;
        set_env(s);
        drive_fields(s);
        @(posedge g_clk);
        #1;
        s3_valid = 1'b0;
        repeat (2) @(posedge g_clk);
        #3;
        g_resetn = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        exp_q.delete();
        @(negedge g_clk);
        g_resetn = 1'b1;
        ev0 = ev_cnt;
        @(posedge g_clk);
        #1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge g_clk);
        #1;
        dmem_rsp_valid = 1'b0;
        repeat (3) @(negedge g_clk);
        chk("orphan_events", 64'(ev_cnt - ev0), 64'd0);
        chk("orphan_s3_ready", s3_ready, 1'b1);
        @(posedge g_clk);
        #1;

        for (int i = 0; i < 250; i++) begin
            s = rand_stim();
            run_instr(s);
            if (i % 50 == 49) burst3();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
